// File: rtl/asteroid_motion_pool.sv
// asteroid_motion_pool: time-multiplexed motion engine for NUM_AST asteroid slots.
// Ports:
//   clk, resetN                       clock, async active-low reset
//   game_continue, vsync, clear       frame control (clear is synchronous)
//   spawn_valid/ready, spawn_*        spawn handshake and payload
//   hit_valid/ready, hit_idx          hit/split handshake
//   rd_idx -> rd_active/x/y/type      registered read port (1-cycle latency)
//   active_mask, busy, frame_overrun  status

package asteroid_motion_pool_pkg;
  typedef logic [1:0] ast_t;
  localparam ast_t AST_LARGE  = 2'd0;
  localparam ast_t AST_MEDIUM = 2'd1;
  localparam ast_t AST_SMALL  = 2'd2;
endpackage

module asteroid_motion_pool
  import asteroid_motion_pool_pkg::*;
#(
  parameter int unsigned NUM_AST  = 8,
  parameter int unsigned WIDTH    = 640,
  parameter int unsigned HEIGHT   = 480,
  parameter int unsigned FRAC     = 6,
  parameter int unsigned VEL_W    = 10,
  parameter bit          SPLIT_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         game_continue,
  input  logic                         vsync,
  input  logic                         clear,
  input  logic                         spawn_valid,
  output logic                         spawn_ready,
  input  logic [$clog2(WIDTH)-1:0]     spawn_x,
  input  logic [$clog2(HEIGHT)-1:0]    spawn_y,
  input  logic signed [VEL_W-1:0]      spawn_dx,
  input  logic signed [VEL_W-1:0]      spawn_dy,
  input  ast_t                         spawn_type,
  input  logic                         hit_valid,
  output logic                         hit_ready,
  input  logic [$clog2(NUM_AST)-1:0]   hit_idx,
  input  logic [$clog2(NUM_AST)-1:0]   rd_idx,
  output logic                         rd_active,
  output logic [$clog2(WIDTH)-1:0]     rd_x,
  output logic [$clog2(HEIGHT)-1:0]    rd_y,
  output ast_t                         rd_type,
  output logic [NUM_AST-1:0]           active_mask,
  output logic                         busy,
  output logic                         frame_overrun
);

  localparam int unsigned IW    = $clog2(NUM_AST);
  localparam int unsigned XW    = $clog2(WIDTH);
  localparam int unsigned YW    = $clog2(HEIGHT);
  localparam int unsigned PXW   = XW + FRAC;
  localparam int unsigned PYW   = YW + FRAC;
  localparam int unsigned PMW   = (PXW > PYW) ? PXW : PYW;
  localparam int unsigned SW    = ((PMW + 2) > (VEL_W + 1)) ? (PMW + 2) : (VEL_W + 1);
  localparam int unsigned DEPTH = 1 << IW;

  localparam logic signed [SW-1:0] LIM_X   = SW'(WIDTH << FRAC);
  localparam logic signed [SW-1:0] LIM_Y   = SW'(HEIGHT << FRAC);
  // Index decode guard for non-power-of-two slot counts
  localparam logic [DEPTH-1:0]     SLOT_OK = DEPTH'({NUM_AST{1'b1}});

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UPDATE = 2'd1;
  localparam logic [1:0] ST_SPLIT  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           split_q, split_d;
  logic                    pend_q, pend_d;
  logic                    ovr_q, ovr_d;
  logic                    busy_q, busy_d;
  logic [NUM_AST-1:0]      act_q, act_d;
  logic [PXW-1:0]          px_q [NUM_AST];
  logic [PXW-1:0]          px_d [NUM_AST];
  logic [PYW-1:0]          py_q [NUM_AST];
  logic [PYW-1:0]          py_d [NUM_AST];
  logic signed [VEL_W-1:0] vx_q [NUM_AST];
  logic signed [VEL_W-1:0] vx_d [NUM_AST];
  logic signed [VEL_W-1:0] vy_q [NUM_AST];
  logic signed [VEL_W-1:0] vy_d [NUM_AST];
  ast_t                    typ_q [NUM_AST];
  ast_t                    typ_d [NUM_AST];

  logic                    rd_active_q, rd_active_d;
  logic [XW-1:0]           rd_x_q, rd_x_d;
  logic [YW-1:0]           rd_y_q, rd_y_d;
  ast_t                    rd_type_q, rd_type_d;

  logic                    free_found;
  logic [IW-1:0]           free_idx;
  logic [IW-1:0]           rd_sel;
  logic signed [VEL_W-1:0] sdx, sdy, hdx, hdy;
  logic signed [VEL_W-1:0] c1x, c1y, c2x, c2y;

  // One wrapped position step: p + v, folded back into [0, lim)
  function automatic logic [PMW-1:0] wrap_step(input logic [PMW-1:0] p,
                                               input logic signed [VEL_W-1:0] v,
                                               input logic signed [SW-1:0] lim);
    logic signed [SW-1:0] n;
    n = $signed(SW'(p)) + SW'(v);
    if (n[SW-1])        n = n + lim;
    else if (n >= lim)  n = n - lim;
    return n[PMW-1:0];
  endfunction

  // Clamp a VEL_W+1 bit sum into the signed VEL_W range
  function automatic logic signed [VEL_W-1:0] sat_v(input logic signed [VEL_W:0] s);
    if (s[VEL_W] != s[VEL_W-1])
      return s[VEL_W] ? {1'b1, {(VEL_W-1){1'b0}}} : {1'b0, {(VEL_W-1){1'b1}}};
    return s[VEL_W-1:0];
  endfunction

  // Next-state, slot update and handshake logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    split_d     = split_q;
    act_d       = act_q;
    px_d        = px_q;
    py_d        = py_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    typ_d       = typ_q;
    spawn_ready = 1'b0;
    hit_ready   = 1'b0;
    pend_d      = pend_q | vsync;
    ovr_d       = ovr_q | (vsync & pend_q);

    // Lowest free slot, shared by spawn and second split child
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_AST; i++) begin
      if (!act_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end

    // Split children velocities, from the slot latched on entry to SPLIT
    sdx = vx_q[split_q];
    sdy = vy_q[split_q];
    hdx = sdx >>> 1;
    hdy = sdy >>> 1;
    c1x = sat_v((VEL_W+1)'(sdx) + (VEL_W+1)'(hdy));
    c1y = sat_v((VEL_W+1)'(sdy) - (VEL_W+1)'(hdx));
    c2x = sat_v((VEL_W+1)'(sdx) - (VEL_W+1)'(hdy));
    c2y = sat_v((VEL_W+1)'(sdy) + (VEL_W+1)'(hdx));

    case (state_q)
      ST_IDLE: begin
        if (pend_q && game_continue) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
          pend_d  = vsync;  // a vsync landing this very cycle stays pending
        end else if (hit_valid) begin
          hit_ready = 1'b1;
          if (SLOT_OK[hit_idx] && act_q[hit_idx]) begin
            // Type 3 is never spawned legitimately; treat it as smallest
            if (!SPLIT_EN || (typ_q[hit_idx] >= AST_SMALL)) begin
              act_d[hit_idx] = 1'b0;
            end else begin
              state_d = ST_SPLIT;
              split_d = hit_idx;
            end
          end
        end else if (spawn_valid && free_found) begin
          spawn_ready      = 1'b1;
          act_d[free_idx]  = 1'b1;
          px_d[free_idx]   = {spawn_x, {FRAC{1'b0}}};
          py_d[free_idx]   = {spawn_y, {FRAC{1'b0}}};
          vx_d[free_idx]   = spawn_dx;
          vy_d[free_idx]   = spawn_dy;
          typ_d[free_idx]  = spawn_type;
        end
      end
      ST_UPDATE: begin
        if (act_q[idx_q]) begin
          px_d[idx_q] = PXW'(wrap_step(PMW'(px_q[idx_q]), vx_q[idx_q], LIM_X));
          py_d[idx_q] = PYW'(wrap_step(PMW'(py_q[idx_q]), vy_q[idx_q], LIM_Y));
        end
        if (idx_q == IW'(NUM_AST - 1)) state_d = ST_IDLE;
        else                           idx_d   = idx_q + IW'(1);
      end
      ST_SPLIT: begin
        typ_d[split_q] = typ_q[split_q] + 2'd1;
        vx_d[split_q]  = c1x;
        vy_d[split_q]  = c1y;
        if (free_found) begin
          act_d[free_idx] = 1'b1;
          px_d[free_idx]  = px_q[split_q];
          py_d[free_idx]  = py_q[split_q];
          vx_d[free_idx]  = c2x;
          vy_d[free_idx]  = c2y;
          typ_d[free_idx] = typ_q[split_q] + 2'd1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      act_d       = '0;
      pend_d      = 1'b0;
      ovr_d       = 1'b0;
      spawn_ready = 1'b0;
      hit_ready   = 1'b0;
    end

    // Readies are combinational; keep them low while held in reset
    if (!resetN) begin
      spawn_ready = 1'b0;
      hit_ready   = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);

    rd_sel      = SLOT_OK[rd_idx] ? rd_idx : '0;
    rd_active_d = SLOT_OK[rd_idx] & act_q[rd_sel];
    rd_x_d      = px_q[rd_sel][PXW-1:FRAC];
    rd_y_d      = py_q[rd_sel][PYW-1:FRAC];
    rd_type_d   = typ_q[rd_sel];
  end

  // State registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      split_q     <= '0;
      pend_q      <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
      act_q       <= '0;
      rd_active_q <= 1'b0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      rd_type_q   <= AST_LARGE;
      for (int i = 0; i < NUM_AST; i++) begin
        px_q[i]  <= '0;
        py_q[i]  <= '0;
        vx_q[i]  <= '0;
        vy_q[i]  <= '0;
        typ_q[i] <= AST_LARGE;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      split_q     <= split_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
      act_q       <= act_d;
      rd_active_q <= rd_active_d;
      rd_x_q      <= rd_x_d;
      rd_y_q      <= rd_y_d;
      rd_type_q   <= rd_type_d;
      px_q        <= px_d;
      py_q        <= py_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      typ_q       <= typ_d;
    end
  end

  assign rd_active     = rd_active_q;
  assign rd_x          = rd_x_q;
  assign rd_y          = rd_y_q;
  assign rd_type       = rd_type_q;
  assign active_mask   = act_q;
  assign busy          = busy_q;
  assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_asteroid_motion_pool.sv
// Directed bench for asteroid_motion_pool; read-port expectations go through a queue.
module tb_asteroid_motion_pool;
  import asteroid_motion_pool_pkg::*;

  localparam int unsigned NUM_AST = 8;
  localparam int unsigned WIDTH   = 640;
  localparam int unsigned HEIGHT  = 480;
  localparam int unsigned FRAC    = 6;
  localparam int unsigned VEL_W   = 10;
  localparam int unsigned IW      = $clog2(NUM_AST);
  localparam int unsigned XW      = $clog2(WIDTH);
  localparam int unsigned YW      = $clog2(HEIGHT);

  logic                    clk, resetN;
  logic                    game_continue, vsync, clear;
  logic                    spawn_valid, spawn_ready;
  logic [XW-1:0]           spawn_x;
  logic [YW-1:0]           spawn_y;
  logic signed [VEL_W-1:0] spawn_dx, spawn_dy;
  ast_t                    spawn_type;
  logic                    hit_valid, hit_ready;
  logic [IW-1:0]           hit_idx, rd_idx;
  logic                    rd_active;
  logic [XW-1:0]           rd_x;
  logic [YW-1:0]           rd_y;
  ast_t                    rd_type;
  logic [NUM_AST-1:0]      active_mask;
  logic                    busy, frame_overrun;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string         tag;
    logic          act;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    ast_t          t;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  asteroid_motion_pool #(
    .NUM_AST(NUM_AST), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .FRAC(FRAC), .VEL_W(VEL_W), .SPLIT_EN(1'b1)
  ) dut (
    .clk(clk), .resetN(resetN), .game_continue(game_continue), .vsync(vsync),
    .clear(clear), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dx(spawn_dx), .spawn_dy(spawn_dy),
    .spawn_type(spawn_type), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_idx(hit_idx), .rd_idx(rd_idx), .rd_active(rd_active), .rd_x(rd_x),
    .rd_y(rd_y), .rd_type(rd_type), .active_mask(active_mask), .busy(busy),
    .frame_overrun(frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic read_slot(input int idx, input logic a, input int x, input int y,
                           input ast_t t, input string tag);
    rd_exp_t e;
    rd_idx = IW'(idx);
    e.tag = tag; e.act = a; e.x = XW'(x); e.y = YW'(y); e.t = t;
    sb_q.push_back(e);
    tick();
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_act"},  32'(rd_active), 32'(e.act));
      chk({e.tag, "_x"},    32'(rd_x),      32'(e.x));
      chk({e.tag, "_y"},    32'(rd_y),      32'(e.y));
      chk({e.tag, "_type"}, 32'(rd_type),   32'(e.t));
    end
  endtask

  task automatic spawn(input int x, input int y, input int dx, input int dy,
                       input ast_t t, input logic exp_rdy, input string tag);
    spawn_valid = 1'b1;
    spawn_x = XW'(x); spawn_y = YW'(y);
    spawn_dx = VEL_W'(dx); spawn_dy = VEL_W'(dy); spawn_type = t;
    #1;
    chk({tag, "_spawn_ready"}, 32'(spawn_ready), 32'(exp_rdy));
    tick();
    spawn_valid = 1'b0;
  endtask

  task automatic hit(input int idx, input string tag);
    hit_valid = 1'b1;
    hit_idx   = IW'(idx);
    #1;
    chk({tag, "_hit_ready"}, 32'(hit_ready), 32'd1);
    tick();
    hit_valid = 1'b0;
  endtask

  // Waits for an update pass to start, then counts its busy cycles
  task automatic wait_update(input string tag);
    int c;
    c = 0;
    while (busy !== 1'b1 && c < 4) begin tick(); c++; end
    chk({tag, "_start"}, 32'(busy), 32'd1);
    c = 0;
    while (busy === 1'b1 && c < 64) begin tick(); c++; end
    chk({tag, "_len"}, 32'(c), NUM_AST);
  endtask

  task automatic frame(input string tag);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    wait_update(tag);
  endtask

  initial begin
    resetN = 1'b0; game_continue = 1'b1; vsync = 1'b0; clear = 1'b0;
    spawn_valid = 1'b1; spawn_x = '0; spawn_y = '0; spawn_dx = '0; spawn_dy = '0;
    spawn_type = AST_LARGE; hit_valid = 1'b1; hit_idx = '0; rd_idx = '0;
    #1;
    chk("rst_spawn_ready", 32'(spawn_ready), 32'd0);
    chk("rst_hit_ready",   32'(hit_ready),   32'd0);
    repeat (3) tick();
    chk("rst_mask",    32'(active_mask),   32'd0);
    chk("rst_busy",    32'(busy),          32'd0);
    chk("rst_overrun", 32'(frame_overrun), 32'd0);
    chk("rst_rd_x",    32'(rd_x),          32'd0);
    spawn_valid = 1'b0; hit_valid = 1'b0;
    resetN = 1'b1;
    tick();

    // Basic spawn and one frame of motion
    spawn(100, 50, 64, -32, AST_LARGE, 1'b1, "sp0");
    chk("sp0_mask", 32'(active_mask), 32'h01);
    read_slot(0, 1'b1, 100, 50, AST_LARGE, "sp0_rd");
    frame("f1");
    read_slot(0, 1'b1, 101, 49, AST_LARGE, "f1_s0");

    // Wrap in both directions on x and y
    spawn(639, 479, 64, 64, AST_SMALL, 1'b1, "sp1");
    spawn(0, 0, -64, -64, AST_SMALL, 1'b1, "sp2");
    chk("sp12_mask", 32'(active_mask), 32'h07);
    frame("f2");
    read_slot(1, 1'b1, 0, 0, AST_SMALL, "wrap_hi");
    read_slot(2, 1'b1, 639, 479, AST_SMALL, "wrap_lo");
    read_slot(0, 1'b1, 102, 49, AST_LARGE, "f2_s0");

    // Fill the pool; a further spawn must stall until a slot frees
    for (int i = 3; i < NUM_AST; i++) spawn(10 * i, 20, 0, 0, AST_SMALL, 1'b1, "fill");
    chk("full_mask", 32'(active_mask), 32'hFF);
    spawn_valid = 1'b1; spawn_x = XW'(321); spawn_y = YW'(123);
    spawn_dx = VEL_W'(5); spawn_dy = VEL_W'(5); spawn_type = AST_LARGE;
    #1;
    chk("full_stall0", 32'(spawn_ready), 32'd0);
    tick();
    chk("full_stall1", 32'(spawn_ready), 32'd0);
    hit_valid = 1'b1; hit_idx = IW'(1);
    #1;
    chk("full_hit_ready",   32'(hit_ready),   32'd1);
    chk("full_hit_prio",    32'(spawn_ready), 32'd0);
    tick();
    hit_valid = 1'b0;
    #1;
    chk("full_freed_mask",  32'(active_mask), 32'hFD);
    chk("full_spawn_ready", 32'(spawn_ready), 32'd1);
    tick();
    spawn_valid = 1'b0;
    chk("refill_mask", 32'(active_mask), 32'hFF);
    read_slot(1, 1'b1, 321, 123, AST_LARGE, "refill_rd");

    // Hit SMALL slots, then split a LARGE one
    hit(2, "hs2");
    chk("hs2_mask", 32'(active_mask), 32'hFB);
    hit(4, "hs4");
    chk("hs4_mask", 32'(active_mask), 32'hEB);
    spawn(200, 100, 64, 0, AST_LARGE, 1'b1, "spL");
    chk("spL_mask", 32'(active_mask), 32'hEF);
    hit(2, "split");
    chk("split_busy", 32'(busy), 32'd1);
    tick();
    chk("split_done_busy", 32'(busy), 32'd0);
    chk("split_mask", 32'(active_mask), 32'hFF);
    read_slot(2, 1'b1, 200, 100, AST_MEDIUM, "child1");
    read_slot(4, 1'b1, 200, 100, AST_MEDIUM, "child2");
    frame("f3");
    read_slot(2, 1'b1, 201, 99,  AST_MEDIUM, "child1_mv");
    read_slot(4, 1'b1, 201, 100, AST_MEDIUM, "child2_mv");
    read_slot(0, 1'b1, 103, 48,  AST_LARGE,  "f3_s0");

    // Back-to-back vsyncs: overrun, and a second pass follows the first
    chk("pre_overrun", 32'(frame_overrun), 32'd0);
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    chk("overrun", 32'(frame_overrun), 32'd1);
    wait_update("ov_a");
    wait_update("ov_b");
    read_slot(0, 1'b1, 105, 47, AST_LARGE, "ov_s0");

    // Frozen game: pending held, handshakes still live
    game_continue = 1'b0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (3) tick();
    chk("frozen_busy", 32'(busy), 32'd0);
    hit(3, "frz_hit");
    chk("frz_hit_mask", 32'(active_mask), 32'hF7);
    spawn(7, 8, 0, 0, AST_SMALL, 1'b1, "frz_sp");
    chk("frz_sp_mask", 32'(active_mask), 32'hFF);
    read_slot(3, 1'b1, 7, 8, AST_SMALL, "frz_rd3");
    read_slot(0, 1'b1, 105, 47, AST_LARGE, "frz_s0");
    game_continue = 1'b1;
    wait_update("resume");
    read_slot(0, 1'b1, 106, 47, AST_LARGE, "resume_s0");

    // Clear in the middle of an update pass, with a vsync pending
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (3) tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_mask",    32'(active_mask),   32'd0);
    chk("clr_busy",    32'(busy),          32'd0);
    chk("clr_overrun", 32'(frame_overrun), 32'd0);
    repeat (3) tick();
    chk("clr_no_pend", 32'(busy), 32'd0);
    hit(5, "hit_inactive");
    chk("hit_inactive_mask", 32'(active_mask), 32'd0);

    // Async reset in the middle of a split
    spawn(50, 60, 0, 0, AST_LARGE, 1'b1, "sp_r");
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    wait_update("pre_r_a");
    wait_update("pre_r_b");
    chk("pre_r_overrun", 32'(frame_overrun), 32'd1);
    read_slot(0, 1'b1, 50, 60, AST_LARGE, "pre_r_rd");
    hit(0, "r_split");
    chk("r_split_busy", 32'(busy), 32'd1);
    spawn_valid = 1'b1;
    hit_valid   = 1'b1;
    resetN      = 1'b0;
    #1;
    chk("ar_mask",        32'(active_mask),   32'd0);
    chk("ar_busy",        32'(busy),          32'd0);
    chk("ar_overrun",     32'(frame_overrun), 32'd0);
    chk("ar_rd_active",   32'(rd_active),     32'd0);
    chk("ar_rd_x",        32'(rd_x),          32'd0);
    chk("ar_rd_y",        32'(rd_y),          32'd0);
    chk("ar_spawn_ready", 32'(spawn_ready),   32'd0);
    chk("ar_hit_ready",   32'(hit_ready),     32'd0);
    spawn_valid = 1'b0;
    hit_valid   = 1'b0;
    tick();
    resetN = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
